// File: rtl/sample_ring_capture_pkg.sv
// Shared types and sizing for the sample ring capture block.
// Holds the controller state encoding and default capture geometry.
package sample_ring_capture_pkg;

    localparam int CAP_DEPTH  = 2048;
    localparam int CAP_ADDR_W = 11;
    localparam int CAP_WORD_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        POST,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } cap_state_t;

endpackage

// File: rtl/sample_ring_capture_ring_addr_counter.sv
// Power-of-two ring pointer with load, increment or decrement, and a wrap flag.
// Latency: pointer updates on the next edge; wrap is combinational for the current step.
module ring_addr_counter #(
    parameter int ADDR_W = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] ptr,
    output logic              wrap
);
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_TOP = {ADDR_W{1'b1}};

    assign wrap = (inc && (ptr == PTR_TOP)) || (dec && (ptr == '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + PTR_ONE;
        end else if (dec) begin
            ptr <= ptr - PTR_ONE;
        end
    end

endmodule

// File: rtl/sample_ring_capture.sv
// Pre/post-trigger sample capture into an external ring RAM, then streamed readout.
// Latency: writes same cycle as sample_valid; readout one word per >=3 cycles; out_ready stalls hold out_data.
// SAMPLE_RING_READ_BACKWARD_EN: read back newest->oldest instead of oldest->newest.
module sample_ring_capture
    import sample_ring_capture_pkg::*;
#(
    parameter int DEPTH  = CAP_DEPTH,
    parameter int ADDR_W = CAP_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic [ADDR_W:0]       post_count,
    input  logic                  sample_valid,
    input  logic [7:0]            sample_data,
    input  logic                  sample_tag,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [7:0]            ram_di,
    output logic                  ram_dip,
    output logic                  ram_en,
    output logic                  ram_we,
    input  logic [7:0]            ram_do,
    input  logic                  ram_dop,
    output logic                  out_valid,
    output logic [CAP_WORD_W-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    cap_state_t        state;
    logic [ADDR_W:0]   post_left;
    logic [ADDR_W:0]   rd_left;
    logic              wrapped;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_wrap;
    logic              rd_wrap_unused;

    logic              trig_arm;
    logic              wr_en;
    logic              counted;
    logic              capture_end;
    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic              wrapped_nxt;
    logic [ADDR_W:0]   rd_len;
    logic [ADDR_W-1:0] rd_start;
    logic              rd_inc;
    logic              rd_dec;

    // With post_count=0 the trigger-cycle sample is dropped; otherwise it is the first post sample.
    assign trig_arm    = (state == ARMED) && trigger;
    assign wr_en       = sample_valid &&
                         ((state == POST) || ((state == ARMED) && !(trigger && (post_left == '0))));
    assign counted     = wr_en && ((state == POST) || trig_arm);
    assign capture_end = (trig_arm && (post_left == '0)) || (counted && (post_left == CNT_ONE));

    // Readout setup must see the pointer as it will be after this cycle's final write.
    assign wr_ptr_nxt  = wr_en ? (wr_ptr + PTR_ONE) : wr_ptr;
    assign wrapped_nxt = wrapped || wr_wrap;
    assign rd_len      = wrapped_nxt ? DEPTH_CNT : {1'b0, wr_ptr_nxt};

`ifdef SAMPLE_RING_READ_BACKWARD_EN
    assign rd_start = wr_ptr_nxt - PTR_ONE;
    assign rd_inc   = 1'b0;
    assign rd_dec   = (state == RD_ISSUE);
`else
    assign rd_start = wrapped_nxt ? wr_ptr_nxt : '0;
    assign rd_inc   = (state == RD_ISSUE);
    assign rd_dec   = 1'b0;
`endif

    ring_addr_counter #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clock    (clock),
        .reset    (reset),
        .load     ((state == IDLE) && arm),
        .load_val ('0),
        .inc      (wr_en),
        .dec      (1'b0),
        .ptr      (wr_ptr),
        .wrap     (wr_wrap)
    );

    ring_addr_counter #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clock    (clock),
        .reset    (reset),
        .load     (capture_end),
        .load_val (rd_start),
        .inc      (rd_inc),
        .dec      (rd_dec),
        .ptr      (rd_ptr),
        .wrap     (rd_wrap_unused)
    );

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        ram_dip  = 1'b0;
        if (wr_en) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wr_ptr;
            ram_di   = sample_data;
            ram_dip  = sample_tag;
        end else if (state == RD_ISSUE) begin
            ram_en   = 1'b1;
            ram_addr = rd_ptr;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            post_left <= '0;
            rd_left   <= '0;
            wrapped   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state     <= ARMED;
                        wrapped   <= 1'b0;
                        post_left <= post_count;
                    end
                end
                ARMED, POST: begin
                    if (wr_wrap) begin
                        wrapped <= 1'b1;
                    end
                    if (counted) begin
                        post_left <= post_left - CNT_ONE;
                    end
                    if (capture_end) begin
                        if (rd_len == '0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state   <= RD_ISSUE;
                            rd_left <= rd_len;
                        end
                    end else if (trig_arm) begin
                        state <= POST;
                    end
                end
                RD_ISSUE: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    out_data  <= {ram_dop, ram_do};
                    out_valid <= 1'b1;
                    state     <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rd_left   <= rd_left - CNT_ONE;
                        if (rd_left == CNT_ONE) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= RD_ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_ring_capture.sv
// Bench for sample_ring_capture: external RAM model, queue-based reference of captured samples.
module tb_sample_ring_capture;
    import sample_ring_capture_pkg::*;

    localparam int DEPTH  = CAP_DEPTH;
    localparam int ADDR_W = CAP_ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              arm;
    logic              trigger;
    logic [ADDR_W:0]   post_count;
    logic              sample_valid;
    logic [7:0]        sample_data;
    logic              sample_tag;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_di;
    logic              ram_dip;
    logic              ram_en;
    logic              ram_we;
    logic [7:0]        ram_do;
    logic              ram_dop;
    logic              out_valid;
    logic [8:0]        out_data;
    logic              out_ready;
    logic              busy;
    logic              done;

    sample_ring_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .arm          (arm),
        .trigger      (trigger),
        .post_count   (post_count),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_tag   (sample_tag),
        .ram_addr     (ram_addr),
        .ram_di       (ram_di),
        .ram_dip      (ram_dip),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_do       (ram_do),
        .ram_dop      (ram_dop),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    // Synchronous single-port RAM with registered read data
    logic [8:0] mem [0:DEPTH-1];
    logic [8:0] rdq = '0;
    always @(posedge clock) begin
        if (ram_en === 1'b1) begin
            if (ram_we === 1'b1) mem[ram_addr] <= {ram_dip, ram_di};
            else                 rdq <= mem[ram_addr];
        end
    end
    assign ram_do  = rdq[7:0];
    assign ram_dop = rdq[8];

    int done_seen = 0;
    always @(posedge clock) if (done === 1'b1) done_seen++;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] wq[$];
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    bit         wr_bad;
    bit         wrap_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one cycle of inputs and confirm the write port; accepted samples enter the model queue.
    task automatic drive(input bit v, input logic [8:0] w, input bit trig, input bit a, input bit exp_we);
        logic [ADDR_W-1:0] ea;
        sample_valid = v;
        sample_data  = w[7:0];
        sample_tag   = w[8];
        trigger      = trig;
        arm          = a;
        #1;
        if (ram_we !== exp_we) wr_bad = 1'b1;
        if (exp_we) begin
            ea = ADDR_W'(wq.size());
            if (ram_en !== 1'b1 || ram_addr !== ea || {ram_dip, ram_di} !== w) wr_bad = 1'b1;
            wq.push_back(w);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic capture(input int pc, input int n_pre, input bit trig_v, input bit seq, input int extra);
        int         cnt;
        int         rem;
        bit         v;
        logic [8:0] w;
        wq.delete();
        wr_bad     = 1'b0;
        cnt        = 0;
        post_count = (ADDR_W+1)'(pc);
        drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        while (cnt < n_pre) begin
            v = seq ? 1'b1 : ($urandom_range(3) != 0);
            w = seq ? 9'(cnt) : 9'($urandom);
            drive(v, w, 1'b0, 1'b0, v);
            if (v) cnt++;
        end
        w = seq ? 9'(cnt) : 9'($urandom);
        drive(trig_v, w, 1'b1, 1'b0, trig_v && (pc > 0));
        cnt++;
        rem = (pc == 0) ? 0 : (trig_v ? pc - 1 : pc);
        while (rem > 0) begin
            v = seq ? 1'b1 : ($urandom_range(3) != 0);
            w = seq ? 9'(cnt) : 9'($urandom);
            drive(v, w, 1'b0, 1'b0, v);
            if (v) begin
                rem--;
                cnt++;
            end
        end
        for (int i = 0; i < extra; i++)
            drive(1'b1, 9'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
        sample_valid = 1'b0;
        trigger      = 1'b0;
        arm          = 1'b0;
        check("write_port", 32'(wr_bad), 32'd0);
    endtask

    // Reference: the last min(N, DEPTH) captured samples, oldest first (or newest first).
    task automatic build_expected();
        int n;
        int l;
        n = wq.size();
        l = (n < DEPTH) ? n : DEPTH;
        exp_q.delete();
        for (int i = 0; i < l; i++) begin
`ifdef SAMPLE_RING_READ_BACKWARD_EN
            exp_q.push_back(wq[n-1-i]);
`else
            exp_q.push_back(wq[n-l+i]);
`endif
        end
    endtask

    task automatic collect(input bit stall, input int budget);
        int         cyc;
        int         stall_cnt;
        int         prev_rd;
        bit         held;
        bit         hold_bad;
        bit         we_bad;
        logic [8:0] held_dat;
        cyc = 0; stall_cnt = 0; prev_rd = -1;
        held = 1'b0; hold_bad = 1'b0; we_bad = 1'b0; held_dat = '0;
        got_q.delete();
        wrap_seen = 1'b0;
        while (busy === 1'b1 && cyc < budget) begin
            if (stall && got_q.size() == 3 && out_valid === 1'b1 && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = stall ? 1'b1 : ($urandom_range(3) != 0);
            end
            if (held && (out_valid !== 1'b1 || out_data !== held_dat)) hold_bad = 1'b1;
            if (ram_we !== 1'b0) we_bad = 1'b1;
            if (ram_en === 1'b1) begin
`ifdef SAMPLE_RING_READ_BACKWARD_EN
                if (prev_rd == 0 && int'(ram_addr) == DEPTH - 1) wrap_seen = 1'b1;
`else
                if (prev_rd == DEPTH - 1 && ram_addr == '0) wrap_seen = 1'b1;
`endif
                prev_rd = int'(ram_addr);
            end
            if (out_valid === 1'b1 && out_ready) got_q.push_back(out_data);
            held     = (out_valid === 1'b1) && !out_ready;
            held_dat = out_data;
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check("readout_in_budget", 32'(cyc < budget), 32'd1);
        check("hold_stable", 32'(hold_bad), 32'd0);
        check("no_write_in_readout", 32'(we_bad), 32'd0);
        check("done_at_end", 32'(done), 32'd1);
        if (stall) check("stall_cycles", 32'(stall_cnt), 32'd5);
    endtask

    task automatic run(input string tag, input int pc, input int n_pre, input bit trig_v,
                       input bit seq, input bit stall, input int extra);
        int d0;
        int mi;
        int n;
        d0 = done_seen;
        capture(pc, n_pre, trig_v, seq, extra);
        build_expected();
        collect(stall, 20000);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n  = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        mi = -1;
        for (int i = 0; i < n; i++) if (mi < 0 && got_q[i] !== exp_q[i]) mi = i;
        if (mi >= 0)    check({tag, "_word"}, 32'(got_q[mi]), 32'(exp_q[mi]));
        else if (n > 0) check({tag, "_last"}, 32'(got_q[n-1]), 32'(exp_q[n-1]));
        step();
        check({tag, "_done_once"}, 32'(done_seen - d0), 32'd1);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int         d0;
        logic [8:0] first_exp;
        logic [8:0] last_exp;
        reset = 1'b1; arm = 1'b0; trigger = 1'b0; post_count = '0;
        sample_valid = 1'b0; sample_data = '0; sample_tag = 1'b0; out_ready = 1'b0;
        step(); step(); step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_di", 32'({ram_dip, ram_di}), 32'd0);
        reset = 1'b0;
        step();

`ifdef SAMPLE_RING_READ_BACKWARD_EN
        first_exp = 9'h008; last_exp = 9'h000;
`else
        first_exp = 9'h000; last_exp = 9'h008;
`endif
        run("basic", 4, 5, 1'b1, 1'b1, 1'b0, 2);
        check("basic_first", 32'(got_q.size() > 0 ? got_q[0] : 9'h1ff), 32'(first_exp));
        check("basic_final", 32'(got_q.size() > 0 ? got_q[got_q.size()-1] : 9'h1ff), 32'(last_exp));

        run("stall", 6, 10, 1'b1, 1'b0, 1'b1, 3);

        run("post0", 0, 7, 1'b1, 1'b0, 1'b0, 2);
        check("post0_len_rule", 32'(got_q.size()), 32'd7);

        d0 = done_seen;
        capture(0, 0, 1'b1, 1'b0, 0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);
        step();
        check("empty_done_once", 32'(done_seen - d0), 32'd1);

        run("wrap", 16, 2100, 1'b0, 1'b0, 1'b0, 2);
        check("wrap_len_depth", 32'(got_q.size()), 32'(DEPTH));
        check("wrap_addr_seen", 32'(wrap_seen), 32'd1);

        for (int k = 0; k < 3; k++)
            run("rand", int'($urandom_range(50, 1)), int'($urandom_range(80)),
                1'($urandom_range(1)), 1'b0, 1'b0, 2);

        // Abort in the middle of POST; no done may follow
        wq.delete();
        wr_bad = 1'b0;
        post_count = (ADDR_W+1)'(8);
        drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 9'($urandom), 1'b0, 1'b0, 1'b1);
        drive(1'b1, 9'($urandom), 1'b1, 1'b0, 1'b1);
        drive(1'b1, 9'($urandom), 1'b0, 1'b0, 1'b1);
        check("abort_write_port", 32'(wr_bad), 32'd0);
        d0 = done_seen;
        reset = 1'b1;
        sample_valid = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ram_we", 32'(ram_we), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        sample_valid = 1'b0;
        step(); step(); step();
        check("abort_no_done", 32'(done_seen - d0), 32'd0);

        run("after_abort", 4, 5, 1'b1, 1'b1, 1'b0, 2);
        check("after_abort_first", 32'(got_q.size() > 0 ? got_q[0] : 9'h1ff), 32'(first_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sample_ring_capture.md
SAMPLE_RING_CAPTURE -- requirements
Module: sample_ring_capture

Interface
REQ-001 Parameter DEPTH, default 2048, capture RAM words (power of two).
REQ-002 Parameter ADDR_W, default 11, log2(DEPTH).
REQ-003 clock  in  1  single clock for all logic; reset synchronous, active-high, on `reset`.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 arm  in  1  one-cycle pulse; starts pre-trigger capture from IDLE.
REQ-006 trigger  in  1  level from trigger stage; sampled only in ARMED.
REQ-007 post_count  in  ADDR_W+1  samples to store after trigger; latched on arm.
REQ-008 sample_valid  in  1  qualifies sample_data/sample_tag this cycle.
REQ-009 sample_data  in  8  sample byte.
REQ-010 sample_tag  in  1  ninth bit (edge/trigger marker), stored as parity bit.
REQ-011 ram_addr  out  ADDR_W  RAM address; ram_di out 8; ram_dip out 1; ram_en out 1; ram_we out 1.
REQ-012 ram_do  in  8, ram_dop in 1  RAM read data, valid one clock after ram_en with ram_we=0.
REQ-013 out_valid  out  1, out_data out 9 {tag,data}, out_ready in 1  readout stream.
REQ-014 busy  out  1  high in any state except IDLE; done out 1  one-cycle pulse after last readout word accepted.

Function
REQ-015 States SHALL be IDLE, ARMED, POST, RD_ISSUE, RD_WAIT, RD_HOLD.
REQ-016 IDLE->ARMED on arm; wr_ptr<=0, wrapped<=0, post counter<=post_count.
REQ-017 In ARMED and POST each sample_valid SHALL drive ram_en=1, ram_we=1, ram_addr=wr_ptr, ram_di/dip=sample, and advance wr_ptr by 1 next cycle.
REQ-018 wr_ptr SHALL wrap DEPTH-1->0 and set wrapped=1 on that wrap; wrapped stays set until next arm.
REQ-019 ARMED->POST when trigger=1; the trigger-cycle sample, if valid, SHALL be written and counted as first post sample.
REQ-020 POST counter SHALL decrement per written sample; when it reaches 0, next state RD_ISSUE.
REQ-021 post_count=0: ARMED->RD_ISSUE on trigger, trigger-cycle sample NOT written.
REQ-022 Readout length SHALL be DEPTH if wrapped else wr_ptr; length 0 -> straight to IDLE with done pulse.
REQ-023 Readout order SHALL be oldest->newest: start at wrapped ? wr_ptr : 0, increment with wrap.
REQ-024 RD_ISSUE: ram_en=1, ram_we=0; RD_WAIT: capture ram_dop/ram_do into out_data, set out_valid; RD_HOLD: hold until out_ready, then RD_ISSUE or IDLE on last word.
REQ-025 Throughput SHALL be at most one word per 3 cycles; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 arm SHALL be ignored outside IDLE; trigger ignored outside ARMED; sample_valid ignored outside ARMED/POST.
REQ-027 ram_en and ram_we SHALL be 0 in every cycle not listed in REQ-017/REQ-024.

Reset
REQ-028 reset SHALL force IDLE, wr_ptr=0, wrapped=0, counters 0, out_valid=0, out_data=0, done=0, busy=0, ram_en=0, ram_we=0, ram_addr=0, ram_di=0, ram_dip=0.
REQ-029 reset mid-capture or mid-readout SHALL abort without a done pulse; RAM contents are not cleared.

Configuration
REQ-030 Macro SAMPLE_RING_READ_BACKWARD_EN defined: readout newest->oldest, starting at wr_ptr-1 and decrementing with wrap, same length as REQ-022.
REQ-031 Macro undefined: readout oldest->newest per REQ-023.

Structure
REQ-032 Shared package SHALL hold the state enum, CAP_DEPTH=2048, CAP_ADDR_W=11, CAP_WORD_W=9.
REQ-033 One sub-module, ring_addr_counter (load, inc/dec, wrap flag), SHALL be used for both write and read pointers.

Verification
REQ-034 arm, post_count=4, 10 valid samples 0x00..0x09, trigger with sample 0x05 -> writes addr 0..8, out stream 0x000..0x008 (9 words), one done pulse.
REQ-035 arm, post_count=16, 2100 samples before trigger -> wrapped=1, readout 2048 words starting at oldest surviving sample, addr wrap 2047->0 seen.
REQ-036 post_count=0, trigger with sample_valid=1 -> that sample not written, readout length = pre-trigger count.
REQ-037 out_ready low 5 cycles during readout -> out_data unchanged, no word lost or duplicated.
REQ-038 reset asserted mid-POST -> next cycle busy=0, ram_we=0, no done; subsequent arm captures normally.
REQ-039 With SAMPLE_RING_READ_BACKWARD_EN, scenario REQ-034 -> stream 0x008 down to 0x000.
